// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART subsystem
package uart_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker, first set bit at or above ptr with wrap
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int N = 4,
  localparam int W = idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);
  int pos;
  // scan farthest offset first so the closest request to ptr wins last
  always_comb begin
    found = 1'b0;
    idx = '0;
    pos = 0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = (int'(ptr) + i >= N) ? int'(ptr) + i - N : int'(ptr) + i;
      if (req[pos]) begin
        found = 1'b1;
        idx = W'(pos);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin, message-locked arbiter sharing the uart_core TX channel
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TOW = 16,
  localparam int GW = idx_w(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [BYTE_W*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic                   tx_valid,
  output logic [BYTE_W-1:0]      tx_data,
  input  logic                   tx_ready,
  input  logic [NREQ-1:0]        cfg_en,
  input  logic [TOW-1:0]         cfg_timeout,
  output logic                   busy,
  output logic [GW-1:0]          grant_id,
  output logic                   timeout_evt
);
  arb_state_t state;
  logic [GW-1:0] rr_ptr, winner, next_ptr;
  logic [TOW-1:0] idle_cnt;
  logic found, sel_valid, hs, expire;

  uart_rr_pick #(.N(NREQ)) u_pick (
    .req  (req_valid & cfg_en),
    .ptr  (rr_ptr),
    .found(found),
    .idx  (winner)
  );

  assign busy = state == ARB_LOCK;
  assign sel_valid = req_valid[grant_id];
  assign tx_valid = busy & sel_valid;
  assign tx_data = busy ? req_data[grant_id*BYTE_W +: BYTE_W] : '0;
  assign req_ready = busy ? NREQ'(tx_ready) << grant_id : '0;
  assign hs = tx_valid & tx_ready;
  // a presented byte blocks the timeout so it is never abandoned mid-handshake
  assign expire = busy & ~sel_valid & (cfg_timeout != '0) & (idle_cnt == cfg_timeout - 1'b1);
  assign next_ptr = grant_id == GW'(NREQ - 1) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      rr_ptr <= '0;
      grant_id <= '0;
      idle_cnt <= '0;
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= expire;
      if (!busy) begin
        if (found) begin
          state <= ARB_LOCK;
          grant_id <= winner;
          idle_cnt <= '0;
        end
      end else if (hs) begin
        idle_cnt <= '0;
        if (req_last[grant_id]) begin
          state <= ARB_IDLE;
          rr_ptr <= next_ptr;
        end
      end else if (expire) begin
        state <= ARB_IDLE;
        rr_ptr <= next_ptr;
      end else if (!sel_valid && idle_cnt != '1) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed test-plan scenarios plus random traffic against a behavioural model
module tb_uart_tx_arb;
  localparam int NREQ = 4;
  localparam int TOW = 16;

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0] req_valid, req_last, req_ready, cfg_en;
  logic [8*NREQ-1:0] req_data;
  logic tx_valid, tx_ready, busy, timeout_evt;
  logic [7:0] tx_data;
  logic [TOW-1:0] cfg_timeout;
  logic [1:0] grant_id;

  int vectors = 0;
  int miscompares = 0;

  int m_busy, m_gid, m_rr, m_idle, m_evt;

  uart_tx_arb #(.NREQ(NREQ), .TOW(TOW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .cfg_en(cfg_en), .cfg_timeout(cfg_timeout), .busy(busy), .grant_id(grant_id),
    .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_gid = 0; m_rr = 0; m_idle = 0; m_evt = 0;
  endtask

  task automatic check_outputs();
    int hv;
    hv = m_busy != 0 && req_valid[m_gid];
    check("busy", 32'(busy), 32'(m_busy));
    check("grant_id", 32'(grant_id), 32'(m_gid));
    check("tx_valid", 32'(tx_valid), 32'(hv));
    check("tx_data", 32'(tx_data), m_busy != 0 ? 32'(req_data[8*m_gid +: 8]) : 32'd0);
    check("req_ready", 32'(req_ready), (m_busy != 0 && tx_ready) ? 32'(1) << m_gid : 32'd0);
    check("timeout_evt", 32'(timeout_evt), 32'(m_evt));
  endtask

  // behavioural view: owner keeps the channel until a last-byte handshake or an idle timeout
  task automatic model_step();
    logic [NREQ-1:0] pend;
    int c;
    pend = req_valid & cfg_en;
    m_evt = 0;
    if (m_busy == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        c = (m_rr + k) % NREQ;
        if (m_busy == 0 && pend[c]) begin
          m_busy = 1; m_gid = c; m_idle = 0;
        end
      end
    end else if (req_valid[m_gid] && tx_ready) begin
      m_idle = 0;
      if (req_last[m_gid]) begin
        m_busy = 0; m_rr = (m_gid + 1) % NREQ;
      end
    end else if (!req_valid[m_gid]) begin
      if (cfg_timeout != 0 && m_idle == int'(cfg_timeout) - 1) begin
        m_busy = 0; m_rr = (m_gid + 1) % NREQ; m_evt = 1;
      end else if (m_idle < (1 << TOW) - 1) m_idle++;
    end
  endtask

  task automatic cycle();
    #4;
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic put(input int i, input logic v, input logic [7:0] d, input logic l);
    req_valid[i] = v;
    req_data[8*i +: 8] = d;
    req_last[i] = l;
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_data = '0; req_last = '0;
    tx_ready = 1'b1; cfg_en = '1; cfg_timeout = '0;
    model_reset();
    #1;
    check_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    // requester 1 sends 0x41,0x42,0x43
    put(1, 1, 8'h41, 0); cycle();
    check("plan1_gid", 32'(grant_id), 32'd1);
    cycle();
    put(1, 1, 8'h42, 0); cycle();
    put(1, 1, 8'h43, 1); cycle();
    put(1, 0, 8'h00, 0); cycle();
    // 0 and 2 together, two-byte messages, two rounds
    for (int r = 0; r < 2; r++) begin
      put(0, 1, 8'h10, 0); put(2, 1, 8'h20, 0);
      repeat (8) begin
        cycle();
        if (tx_ready && busy) put(grant_id, 1, 8'h30, 1);
      end
    end
    put(0, 0, 0, 0); put(2, 0, 0, 0); cycle(); cycle();
    // masked requester stays idle until enabled
    cfg_en = 4'b1011; put(2, 1, 8'h55, 1);
    repeat (4) cycle();
    cfg_en = 4'b1111; cycle(); cycle(); put(2, 0, 0, 0); cycle();
    // timeout after one non-last byte from requester 3
    cfg_timeout = 5; put(3, 1, 8'h77, 0);
    cycle(); cycle(); put(3, 0, 0, 0);
    repeat (8) cycle();
    // stall: byte held, no timeout
    put(0, 1, 8'h99, 1); tx_ready = 1'b0;
    repeat (21) cycle();
    tx_ready = 1'b1; cycle(); put(0, 0, 0, 0); cycle();
    // reset mid-message after two of four bytes
    put(1, 1, 8'hA1, 0); cycle(); cycle();
    put(1, 1, 8'hA2, 0); cycle();
    put(1, 1, 8'hA3, 0); put(3, 1, 8'hB0, 1);
    async_reset();
    repeat (3) cycle();
    req_valid = '0; cycle();
    // random traffic with occasional config changes and resets
    for (int n = 0; n < 4000; n++) begin
      req_valid = NREQ'($urandom);
      req_data = $urandom;
      for (int i = 0; i < NREQ; i++) req_last[i] = $urandom_range(0, 2) == 0;
      tx_ready = $urandom_range(0, 9) < 7;
      if ($urandom_range(0, 49) == 0) cfg_en = NREQ'($urandom);
      if ($urandom_range(0, 49) == 0) cfg_timeout = TOW'($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) req_valid = '0;
      if ($urandom_range(0, 599) == 0) async_reset();
      else cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
